control_unit: RTL and testbench



---
 rtl/cpu_pkg.sv | 28 ++
 rtl/alu_decoder.sv | 15 +
 rtl/control_unit.sv | 148 ++++++++++++++
 tb/tb_control_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcode, funct, ALU and mux encodings plus control FSM states.
package cpu_pkg;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP
  } state_t;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps R-type funct to an ALU operation; unknown functs fall back to ADD and are flagged.
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_illegal
);
  always_comb begin
    alu_op = funct == FN_SUB ? ALU_SUB :
             funct == FN_AND ? ALU_AND :
             funct == FN_OR  ? ALU_OR  : ALU_ADD;
    funct_illegal = !(funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR});
  end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute/memory/writeback sequencer driving all datapath controls.
module control_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  Op,
  input  logic [5:0]  Funct,
  input  logic        aluZero,
  input  logic        memReady,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic [1:0]  PCSrc,
  output logic        PCEn,
  output logic        illegal,
  output logic [31:0] instrCount
);
  state_t state, next;
  logic [31:0] instr_count;
  logic [3:0] dec_op;
  logic funct_illegal, retire;
  alu_decoder u_dec (.funct(Funct), .alu_op(dec_op), .funct_illegal(funct_illegal));
  assign instrCount = instr_count;
  always_comb begin
    next = state;
    retire = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IorD = 1'b0;
    IRWrite = 1'b0;
    RegWrite = 1'b0;
    RegDst = 1'b0;
    MemtoReg = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = SRCB_REG;
    ALUOp = ALU_ADD;
    PCSrc = PC_ALU;
    PCEn = 1'b0;
    illegal = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = memReady;
        PCEn = memReady;
        next = memReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = SRCB_BR;
        case (Op)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = EXECUTE;
          OP_BEQ:       next = BRANCH;
          OP_ADDI:      next = ADDIEX;
          OP_J:         next = JUMP;
          default: begin
            illegal = 1'b1;
            next = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        next = Op == OP_LW ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        next = memReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        retire = memReady;
        next = memReady ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp = dec_op;
        illegal = funct_illegal;
        next = funct_illegal ? FETCH : ALUWB;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = ALU_SUB;
        PCSrc = PC_ALUOUT;
        PCEn = aluZero;
        retire = 1'b1;
        next = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        next = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      JUMP: begin
        PCSrc = PC_JUMP;
        PCEn = 1'b1;
        retire = 1'b1;
        next = FETCH;
      end
      default: next = FETCH;
    endcase
    // Reset is asynchronous, so the write strobes must drop combinationally, not at the next edge.
    if (!rst_n) begin
      IRWrite = 1'b0;
      PCEn = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
      illegal = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FETCH;
      instr_count <= '0;
    end else begin
      state <= next;
      if (retire) instr_count <= instr_count + 32'd1;
    end
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: scoreboard bench; expected control vectors are queued per cycle and checked at the negedge.
module tb_control_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [5:0] Op = 6'b0, Funct = 6'b0;
  logic aluZero = 1'b0, memReady = 1'b1;
  logic MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, PCEn, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [3:0] ALUOp;
  logic [31:0] instrCount;
  int errors = 0, checks = 0;
  logic [31:0] exp_count = 32'd0;
  typedef struct {string name; logic [17:0] v;} exp_t;
  exp_t sb[$];
  control_unit dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .aluZero(aluZero), .memReady(memReady),
    .MemRead(MemRead), .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCEn(PCEn), .illegal(illegal), .instrCount(instrCount)
  );
  always #5 clk = ~clk;
  wire [17:0] obs = {MemRead, MemWrite, IorD, IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                     ALUSrcB, ALUOp, PCSrc, PCEn, illegal};
  function automatic logic [17:0] ev(input logic mr, mw, iord, irw, rw, rdst, m2r, sa,
                                     input logic [1:0] sb_, input logic [3:0] op,
                                     input logic [1:0] pcs, input logic pe, il);
    return {mr, mw, iord, irw, rw, rdst, m2r, sa, sb_, op, pcs, pe, il};
  endfunction
  function automatic logic [17:0] e_fetch(input logic r);
    return ev(1, 0, 0, r, 0, 0, 0, 0, 2'b01, 4'b0010, 2'b00, r, 0);
  endfunction
  function automatic logic [17:0] e_decode(input logic il);
    return ev(0, 0, 0, 0, 0, 0, 0, 0, 2'b11, 4'b0010, 2'b00, 0, il);
  endfunction
  function automatic logic [17:0] e_exec(input logic [3:0] op, input logic il);
    return ev(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, op, 2'b00, 0, il);
  endfunction
  localparam logic [17:0] E_MEMADR = 18'b0000000_1_10_0010_00_0_0;
  localparam logic [17:0] E_MEMRD  = 18'b1010000_0_00_0010_00_0_0;
  localparam logic [17:0] E_MEMWB  = 18'b0000101_0_00_0010_00_0_0;
  localparam logic [17:0] E_MEMWR  = 18'b0110000_0_00_0010_00_0_0;
  localparam logic [17:0] E_ALUWB  = 18'b0000110_0_00_0010_00_0_0;
  localparam logic [17:0] E_ADDIEX = 18'b0000000_1_10_0010_00_0_0;
  localparam logic [17:0] E_ADDIWB = 18'b0000100_0_00_0010_00_0_0;
  localparam logic [17:0] E_JUMP   = 18'b0000000_0_00_0010_10_1_0;
  function automatic logic [17:0] e_branch(input logic z);
    return ev(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 4'b0110, 2'b01, z, 0);
  endfunction
  // Drive one cycle's inputs, queue its expected outputs, and score them at the negedge.
  task automatic step(input string name, input logic [17:0] e, input logic mr, input logic z);
    exp_t item;
    memReady = mr;
    aluZero = z;
    sb.push_back('{name, e});
    @(negedge clk);
    item = sb.pop_front();
    checks++;
    if (obs !== item.v) begin
      errors++;
      $display("FAIL %s: got %b expected %b", item.name, obs, item.v);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    step("reset_outputs", e_fetch(0), 1, 1);
    checks++;
    if (instrCount !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", instrCount); end
    rst_n = 1'b1;
    exp_count = 0;
  endtask
  task automatic test_alu;
    logic [5:0] fn [4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
    logic [3:0] op [4] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      Op = 6'b000000;
      Funct = fn[i];
      step("r_fetch", e_fetch(1), 1, 0);
      step("r_decode", e_decode(0), 1, 0);
      step("r_execute", e_exec(op[i], 0), 1, 0);
      step("r_aluwb", E_ALUWB, 1, 0);
      exp_count++;
      checks++;
      if (instrCount !== exp_count) begin errors++; $display("FAIL r_count: got %0d expected %0d", instrCount, exp_count); end
    end
  endtask
  task automatic test_lw;
    Op = 6'b100011;
    step("lw_fetch", e_fetch(1), 1, 0);
    step("lw_decode", e_decode(0), 1, 0);
    step("lw_memadr", E_MEMADR, 1, 0);
    step("lw_memrd_wait1", E_MEMRD, 0, 0);
    step("lw_memrd_wait2", E_MEMRD, 0, 0);
    step("lw_memrd_done", E_MEMRD, 1, 0);
    step("lw_memwb", E_MEMWB, 1, 0);
    exp_count++;
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL lw_count: got %0d expected %0d", instrCount, exp_count); end
  endtask
  task automatic test_sw;
    Op = 6'b101011;
    step("sw_fetch_wait", e_fetch(0), 0, 0);
    step("sw_fetch", e_fetch(1), 1, 0);
    step("sw_decode", e_decode(0), 0, 0);
    step("sw_memadr", E_MEMADR, 0, 0);
    step("sw_memwr_wait", E_MEMWR, 0, 0);
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL sw_early_count: got %0d expected %0d", instrCount, exp_count); end
    step("sw_memwr_done", E_MEMWR, 1, 0);
    exp_count++;
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL sw_count: got %0d expected %0d", instrCount, exp_count); end
  endtask
  task automatic test_branch;
    Op = 6'b000100;
    for (int i = 0; i < 2; i++) begin
      step("beq_fetch", e_fetch(1), 1, 0);
      step("beq_decode", e_decode(0), 1, 0);
      step(i == 0 ? "beq_taken" : "beq_not_taken", e_branch(i == 0), 1, i == 0);
      exp_count++;
    end
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL beq_count: got %0d expected %0d", instrCount, exp_count); end
  endtask
  task automatic test_addi_jump;
    Op = 6'b001000;
    step("addi_fetch", e_fetch(1), 1, 0);
    step("addi_decode", e_decode(0), 1, 0);
    step("addi_ex", E_ADDIEX, 1, 0);
    step("addi_wb", E_ADDIWB, 1, 0);
    Op = 6'b000010;
    step("j_fetch", e_fetch(1), 1, 0);
    step("j_decode", e_decode(0), 1, 0);
    step("j_jump", E_JUMP, 1, 0);
    exp_count += 2;
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL addi_j_count: got %0d expected %0d", instrCount, exp_count); end
  endtask
  task automatic test_illegal;
    Op = 6'b111111;
    step("ill_op_fetch", e_fetch(1), 1, 0);
    step("ill_op_decode", e_decode(1), 1, 0);
    Op = 6'b000000;
    Funct = 6'b101010;
    step("ill_fn_fetch", e_fetch(1), 1, 0);
    step("ill_fn_decode", e_decode(0), 1, 0);
    step("ill_fn_execute", e_exec(4'b0010, 1), 1, 0);
    step("ill_back_in_fetch", e_fetch(0), 0, 0);
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL illegal_count: got %0d expected %0d", instrCount, exp_count); end
  endtask
  task automatic test_reset_mid;
    Op = 6'b101011;
    step("rm_fetch", e_fetch(1), 1, 0);
    step("rm_decode", e_decode(0), 1, 0);
    step("rm_memadr", E_MEMADR, 1, 0);
    memReady = 1'b0;
    #2;
    checks++;
    if (MemWrite !== 1'b1) begin errors++; $display("FAIL rm_memwr_before: got %b expected 1", MemWrite); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== e_fetch(0)) begin errors++; $display("FAIL rm_async_outputs: got %b expected %b", obs, e_fetch(0)); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_count = 0;
    checks++;
    if (instrCount !== 32'd0) begin errors++; $display("FAIL rm_count: got %0d expected 0", instrCount); end
    step("rm_post_fetch", e_fetch(1), 1, 0);
    step("rm_post_decode", e_decode(0), 1, 0);
    step("rm_post_memadr", E_MEMADR, 1, 0);
    step("rm_post_memwr", E_MEMWR, 1, 0);
    exp_count++;
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL rm_post_count: got %0d expected %0d", instrCount, exp_count); end
  endtask
  task automatic test_wrap;
    memReady = 1'b0;
    force dut.instr_count = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.instr_count;
    exp_count = 32'hFFFF_FFFF;
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL wrap_preload: got %h expected %h", instrCount, exp_count); end
    Op = 6'b000010;
    step("wrap_fetch", e_fetch(1), 1, 0);
    step("wrap_decode", e_decode(0), 1, 0);
    step("wrap_jump", E_JUMP, 1, 0);
    exp_count++;
    checks++;
    if (instrCount !== exp_count) begin errors++; $display("FAIL wrap_count: got %h expected %h", instrCount, exp_count); end
  endtask
  initial begin
    @(posedge clk);
    #1;
    test_reset;
    test_alu;
    test_lw;
    test_sw;
    test_branch;
    test_addi_jump;
    test_illegal;
    test_reset_mid;
    test_wrap;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: got %0d expected 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
